// File: rtl/instr_fetch_fifo.sv
// instr_fetch_fifo: instruction buffer between the fetch re-aligner and decode.
// Compacts up to INSTR_PER_FETCH valid lanes per cycle, in lane order, into a
// circular buffer and presents one instruction per cycle to decode.
// Optional feature: define INSTR_FIFO_BYPASS_EN to forward the lowest valid
// lane straight to the head outputs when the buffer is empty.
module instr_fetch_fifo #(
    parameter int DEPTH           = 8,
    parameter int INSTR_PER_FETCH = 2,
    parameter int VLEN            = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic [INSTR_PER_FETCH-1:0]        valid_i,
    input  logic [INSTR_PER_FETCH*VLEN-1:0]   addr_i,
    input  logic [INSTR_PER_FETCH*32-1:0]     instr_i,
    output logic                              ready_o,
    output logic                              valid_o,
    output logic [VLEN-1:0]                   addr_o,
    output logic [31:0]                       instr_o,
    output logic                              is_compressed_o,
    input  logic                              ready_i,
    output logic [$clog2(DEPTH):0]            count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - INSTR_PER_FETCH);

    logic [VLEN-1:0] mem_addr  [DEPTH];
    logic [31:0]     mem_instr [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic                                  push_fire;
    logic                                  pop;
    logic                                  bypass_take;
    logic [INSTR_PER_FETCH-1:0]            lane_we;
    logic [INSTR_PER_FETCH-1:0][PW-1:0]    lane_off;
    logic [CW-1:0]                         n_store;
    logic                                  skip_pending;

    // ready only looks at registered occupancy so fetch sees no combinational path
    assign ready_o   = (count <= READY_MAX);
    assign push_fire = ready_o && (|valid_i) && !flush_i;
    assign pop       = (count != '0) && ready_i && !flush_i;
    assign count_o   = count;

`ifdef INSTR_FIFO_BYPASS_EN
    logic            bypass_act;
    logic [VLEN-1:0] byp_addr;
    logic [31:0]     byp_instr;

    assign bypass_act  = (count == '0) && push_fire;
    assign bypass_take = bypass_act && ready_i;

    // pick the lowest-index valid lane as the forwarded instruction
    always_comb begin
        byp_addr  = addr_i[VLEN-1:0];
        byp_instr = instr_i[31:0];
        for (int l = INSTR_PER_FETCH - 1; l >= 0; l--) begin
            if (valid_i[l]) begin
                byp_addr  = addr_i[l*VLEN +: VLEN];
                byp_instr = instr_i[l*32 +: 32];
            end
        end
    end

    // head comes from the bypass lane when empty, otherwise from storage
    always_comb begin
        valid_o = (count != '0) || bypass_act;
        addr_o  = mem_addr[rd_ptr];
        instr_o = mem_instr[rd_ptr];
        if (bypass_act) begin
            addr_o  = byp_addr;
            instr_o = byp_instr;
        end
    end
`else
    assign bypass_take = 1'b0;

    // head is purely registered state in this build
    always_comb begin
        valid_o = (count != '0);
        addr_o  = mem_addr[rd_ptr];
        instr_o = mem_instr[rd_ptr];
    end
`endif

    assign is_compressed_o = (instr_o[1:0] != 2'b11);

    // compact valid lanes into consecutive slots; a consumed bypass lane is skipped
    always_comb begin
        n_store      = '0;
        lane_we      = '0;
        lane_off     = '0;
        skip_pending = bypass_take;
        for (int l = 0; l < INSTR_PER_FETCH; l++) begin
            lane_off[l] = n_store[PW-1:0];
            if (push_fire && valid_i[l]) begin
                if (skip_pending) begin
                    skip_pending = 1'b0;
                end else begin
                    lane_we[l] = 1'b1;
                    n_store    = n_store + CW'(1);
                end
            end
        end
    end

    // entry storage; contents survive flush and reset, only pointers matter
    always_ff @(posedge clk_i) begin
        for (int l = 0; l < INSTR_PER_FETCH; l++) begin
            if (lane_we[l]) begin
                mem_addr[wr_ptr + lane_off[l]]  <= addr_i[l*VLEN +: VLEN];
                mem_instr[wr_ptr + lane_off[l]] <= instr_i[l*32 +: 32];
            end
        end
    end

    // pointer and occupancy update; reset beats flush, flush beats push/pop
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + n_store[PW-1:0];
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + n_store - CW'(pop);
        end
    end

endmodule

// File: tb/tb_instr_fetch_fifo.sv
// Testbench for instr_fetch_fifo: directed steps from the test plan followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_instr_fetch_fifo;

    localparam int RDY_MAX = 6;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic [1:0]  valid_i;
    logic [63:0] addr_i;
    logic [63:0] instr_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] addr_o;
    logic [31:0] instr_o;
    logic        is_compressed_o;
    logic        ready_i;
    logic [3:0]  count_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } entry_t;

    entry_t mq[$];

    instr_fetch_fifo #(.DEPTH(8), .INSTR_PER_FETCH(2), .VLEN(32)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .valid_i         (valid_i),
        .addr_i          (addr_i),
        .instr_i         (instr_i),
        .ready_o         (ready_o),
        .valid_o         (valid_o),
        .addr_o          (addr_o),
        .instr_o         (instr_o),
        .is_compressed_o (is_compressed_o),
        .ready_i         (ready_i),
        .count_o         (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic entry_t lane(input int l);
        entry_t e;
        e.addr  = addr_i[l*32 +: 32];
        e.instr = instr_i[l*32 +: 32];
        return e;
    endfunction

    task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] i0,
                         input logic [31:0] a1, input logic [31:0] i1,
                         input logic r, input logic f);
        valid_i = v;
        addr_i  = {a1, a0};
        instr_i = {i1, i0};
        ready_i = r;
        flush_i = f;
        #1;
    endtask

    // compare current outputs with what the model says should be visible now
    task automatic check_outputs();
        int     cnt;
        logic   exp_v;
        entry_t h;
        cnt   = mq.size();
        exp_v = 1'b0;
        h     = '0;
        if (cnt != 0) begin
            exp_v = 1'b1;
            h     = mq[0];
        end
`ifdef INSTR_FIFO_BYPASS_EN
        else if (!flush_i && valid_i != 2'b00 && cnt <= RDY_MAX) begin
            exp_v = 1'b1;
            h     = valid_i[0] ? lane(0) : lane(1);
        end
`endif
        chk("count", 32'(count_o), 32'(cnt));
        chk("ready", 32'(ready_o), 32'(cnt <= RDY_MAX));
        chk("valid", 32'(valid_o), 32'(exp_v));
        if (exp_v) begin
            chk("addr", addr_o, h.addr);
            chk("instr", instr_o, h.instr);
            chk("is_compressed", 32'(is_compressed_o), 32'(h.instr[1:0] != 2'b11));
        end
    endtask

    // advance one clock and apply the same cycle's effect to the model
    task automatic tick();
        int   cnt;
        logic push;
        logic skip;
        cnt = mq.size();
        @(posedge clk_i);
        if (rst_i || flush_i) begin
            mq.delete();
        end else begin
            push = (cnt <= RDY_MAX) && (valid_i != 2'b00);
            if (cnt != 0 && ready_i) void'(mq.pop_front());
            skip = 1'b0;
`ifdef INSTR_FIFO_BYPASS_EN
            skip = (cnt == 0) && push && ready_i;
`endif
            for (int l = 0; l < 2; l++) begin
                if (push && valid_i[l]) begin
                    if (skip) skip = 1'b0;
                    else mq.push_back(lane(l));
                end
            end
        end
        @(negedge clk_i);
    endtask

    task automatic step(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] i0,
                        input logic [31:0] a1, input logic [31:0] i1,
                        input logic r, input logic f);
        drive(v, a0, i0, a1, i1, r, f);
        check_outputs();
        tick();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        return (w[1:0] == 2'b11) ? w : {16'h0000, w[15:0]};
    endfunction

    initial begin
        logic [1:0]  rv;
        logic        rr;
        logic        rf;
        logic [31:0] ra;

        // reset held two cycles with a full fetch group presented
        rst_i = 1'b1;
        drive(2'b11, 32'h10, 32'h13, 32'h14, 32'h4501, 1'b0, 1'b0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        step(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        // order and compaction
        step(2'b11, 32'h1000, 32'h00A00513, 32'h1004, 32'h00004501, 1'b1, 1'b0);
        step(2'b10, 32'h0, 32'h0, 32'h1006, 32'h00000505, 1'b1, 1'b0);
        step(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

        // fill to full, then pop and refill across the pointer wrap
        for (int k = 0; k < 4; k++)
            step(2'b11, 32'h4000 + 32'(8*k), rand_instr(), 32'h4004 + 32'(8*k), rand_instr(), 1'b0, 1'b0);
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("full_count", 32'(count_o), 32'd8);
        chk("full_ready", 32'(ready_o), 32'd0);
        for (int k = 0; k < 3; k++) step(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(2'b11, 32'h5000, rand_instr(), 32'h5004, rand_instr(), 1'b0, 1'b0);
        step(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

        // simultaneous push and pop at the ready boundary
        drive(2'b11, 32'h6000, rand_instr(), 32'h6004, rand_instr(), 1'b1, 1'b0);
        chk("pp_count_before", 32'(count_o), 32'd6);
        check_outputs();
        tick();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("pp_count_after", 32'(count_o), 32'd7);

        // flush beats push and pop
        step(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(2'b11, 32'h3000, 32'h00000001, 32'h3004, 32'h00000002, 1'b1, 1'b1);
        chk("fl_count_before", 32'(count_o), 32'd5);
        check_outputs();
        tick();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("fl_count", 32'(count_o), 32'd0);
        chk("fl_valid", 32'(valid_o), 32'd0);
        chk("fl_ready", 32'(ready_o), 32'd1);

        // empty-FIFO push with decode ready: bypass vs registered latency
        drive(2'b11, 32'h2000, 32'h00001111, 32'h2004, 32'h00002222, 1'b1, 1'b0);
        check_outputs();
`ifdef INSTR_FIFO_BYPASS_EN
        chk("byp_valid", 32'(valid_o), 32'd1);
        chk("byp_addr", addr_o, 32'h2000);
`else
        chk("nobyp_valid", 32'(valid_o), 32'd0);
`endif
        tick();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef INSTR_FIFO_BYPASS_EN
        chk("byp_next_addr", addr_o, 32'h2004);
        chk("byp_next_count", 32'(count_o), 32'd1);
`else
        chk("nobyp_next_addr", addr_o, 32'h2000);
        chk("nobyp_next_count", 32'(count_o), 32'd2);
`endif
        check_outputs();

        // randomized traffic; fetch only offers lanes while the model says ready
        for (int k = 0; k < 400; k++) begin
            rv = (mq.size() <= RDY_MAX) ? 2'($urandom_range(0, 3)) : 2'b00;
            rr = ($urandom_range(0, 3) != 0);
            rf = ($urandom_range(0, 24) == 0);
            ra = {16'h0, 16'($urandom)} & 32'hFFFF_FFFE;
            step(rv, ra, rand_instr(), ra + 32'd2, rand_instr(), rr, rf);
        end

        // reset mid-operation dominates flush and a pending push
        step(2'b11, 32'h7000, rand_instr(), 32'h7004, rand_instr(), 1'b0, 1'b0);
        step(2'b11, 32'h7008, rand_instr(), 32'h700C, rand_instr(), 1'b0, 1'b0);
        rst_i = 1'b1;
        drive(2'b11, 32'h8000, rand_instr(), 32'h8004, rand_instr(), 1'b1, 1'b1);
        tick();
        rst_i = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("midrst_count", 32'(count_o), 32'd0);
        chk("midrst_valid", 32'(valid_o), 32'd0);
        chk("midrst_ready", 32'(ready_o), 32'd1);
        step(2'b01, 32'h9000, 32'h00000513, 32'h0, 32'h0, 1'b0, 1'b0);
        step(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_fifo.md
# instr_fetch_fifo

Instruction buffer directly downstream of the fetch re-aligner. It accepts up to `INSTR_PER_FETCH` re-aligned instructions per cycle as a lane-valid mask with per-lane address and instruction word. It compacts them in lane order into a circular FIFO and hands them one per cycle to decode with a valid/ready handshake. It provides backpressure to fetch, and a flush discards all buffered instructions.

## Interface
- `DEPTH`, 8, number of entries; power of two, ≥ 4.
- `INSTR_PER_FETCH`, 2, input lanes per cycle (1 or 2).
- `VLEN`, 32, virtual address width.
- `clk_i` in 1: clock; all state updates on rising edge.
- `rst_i` in 1: reset; one clock, synchronous, active-high.
- `flush_i` in 1: discard all entries.
- `valid_i` in `INSTR_PER_FETCH`: per-lane valid; any mask pattern is legal.
- `addr_i` in `INSTR_PER_FETCH`×`VLEN`: per-lane instruction address.
- `instr_i` in `INSTR_PER_FETCH`×32: per-lane instruction; compressed instructions are zero-extended in [31:16].
- `ready_o` out 1: FIFO can accept a full fetch group this cycle.
- `valid_o` out 1: head entry valid.
- `addr_o` out `VLEN`: head address.
- `instr_o` out 32: head instruction.
- `is_compressed_o` out 1: `instr_o[1:0] != 2'b11`.
- `ready_i` in 1: decode consumes the head this cycle.
- `count_o` out `$clog2(DEPTH)+1`: current occupancy.

## Operation
- Storage: `DEPTH` entries of {addr, instr}. Read pointer `rd_ptr` and write pointer `wr_ptr` are `$clog2(DEPTH)` bits and wrap naturally modulo `DEPTH`. Occupancy `count` is held in a separate register.
- `ready_o = (count <= DEPTH - INSTR_PER_FETCH)`. It is computed from registered state only; there is no combinational path from `valid_i` or `ready_i`.
- Push fires when `ready_o && |valid_i && !flush_i`.
  - `n_push` = popcount(`valid_i`).
  - Valid lanes are written in ascending lane index to `wr_ptr`, `wr_ptr+1`, … (mod `DEPTH`). Invalid lanes are skipped, so mask `2'b10` writes lane 1 at `wr_ptr`.
- `valid_i` lanes arriving while `ready_o = 0` are dropped. Fetch must hold its data; the bench treats this as a protocol violation.
- Pop fires when `valid_o && ready_i && !flush_i`. `rd_ptr` advances by 1.
- Count update: `count_next = count + n_push - pop`. Simultaneous push and pop at `count = DEPTH - INSTR_PER_FETCH` is legal, and the count never exceeds `DEPTH`.
- Flush has priority over push and pop in the same cycle. Both pointers and `count` go to 0; entry contents are not cleared.
- Head outputs: `valid_o = (count != 0)`. `addr_o` and `instr_o` are read from `mem[rd_ptr]`. The head is stable while `valid_o && !ready_i && !flush_i`.
- Reset values: `count_o = 0`, `valid_o = 0`, `ready_o = 1`, pointers = 0. `addr_o` and `instr_o` are unspecified (don't-care) while `valid_o = 0`.
- Reset mid-operation: all entries are lost and the next cycle behaves as after power-on. Reset dominates flush.

## Timing
- Default build: enqueue-to-`valid_o` latency is 1 cycle, so an instruction pushed in cycle N is visible at the head in cycle N+1.
- Throughput: sustained 1 instruction/cycle out; up to `INSTR_PER_FETCH` in.
- `ready_o` reflects end-of-previous-cycle occupancy and may deassert one cycle conservatively.
- After flush in cycle N: `valid_o = 0` and `ready_o = 1` in cycle N+1.

## Configuration
- Macro `INSTR_FIFO_BYPASS_EN`.
- Defined: when `count == 0` and push fires, the lowest-index valid lane is driven onto `addr_o`/`instr_o` with `valid_o = 1` in the same cycle.
  - If `ready_i` is also 1, that instruction is not written. Only the remaining lane is stored, and `count` increments by `n_push - 1`.
  - `flush_i` suppresses the bypass.
- Not defined: no bypass path; latency is 1 cycle as above. `valid_o` then depends only on registered state.

## Test plan
- Reset: assert `rst_i` for 2 cycles with `valid_i = 2'b11` → `count_o = 0`, `valid_o = 0`, `ready_o = 1` after release; nothing enqueued.
- Order and compaction: push {0x1000: 0x00A00513, 0x1004: 0x4501} with mask `2'b11`, then mask `2'b10` with lane 1 = {0x1006: 0x0505}; `ready_i = 1` → outputs in order 0x1000, 0x1004, 0x1006; `is_compressed_o` = 0, 1, 1.
- Full and wrap: `ready_i = 0`, push 4 pairs → `count_o = 8`, `ready_o = 0`. Then pop 3 and push 1 pair → the entry order across the pointer wrap is preserved, and `count_o` sequence matches the model.
- Simultaneous push/pop at `count = 6`: mask `2'b11`, `ready_i = 1` → `count_o = 7`, no overflow.
- Flush priority: at `count = 5`, assert `flush_i` with push and pop active → next cycle `count_o = 0`, `valid_o = 0`; the pushed pair is absent.
- Bypass (`INSTR_FIFO_BYPASS_EN`): FIFO empty, push mask `2'b11` {0x2000, 0x2004}, `ready_i = 1` → `valid_o = 1` with `addr_o = 0x2000` in the same cycle; next cycle `addr_o = 0x2004`, `count_o = 1`. Without the macro, 0x2000 appears one cycle later.
